pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 120, payload width: icode+rA+rB+valA+valP+valE = 8+8+8+32+32+32.
REQ-002 Parameter CNT_W, default 16, stall-counter width; used only when PIPE_STALL_CNT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream stage offers in_data.
REQ-006 in_ready  output  1  stage can accept a beat this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 out_valid  output  1  out_data holds a live instruction.
REQ-009 out_ready  input  1  downstream stage consumes out_data this cycle.
REQ-010 out_data  output  DATA_W  payload to the downstream stage.
REQ-011 flush  input  1  synchronous squash of all held beats (mispredict/bubble).
REQ-012 stall_cnt  output  CNT_W  saturating downstream-stall count; present only with PIPE_STALL_CNT_EN.

Function
REQ-013 Two slots SHALL be held: main (drives out_*) and skid (overflow); state = EMPTY (none valid), ONE (main only), FULL (main and skid).
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-015 in_ready SHALL be a register output equal to !skid_valid, with no combinational path from out_ready.
REQ-016 Latency SHALL be 1 cycle: a beat accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the stage was EMPTY or drained in N.
REQ-017 EMPTY->ONE on input; ONE->ONE on simultaneous input+output (main reloaded); ONE->EMPTY on output only; ONE->FULL on input without output (beat captured in skid).
REQ-018 FULL->ONE on output: skid moves to main; no input is accepted in FULL (in_ready=0).
REQ-019 Beats SHALL leave in strict acceptance order; none dropped or duplicated except by flush.
REQ-020 flush SHALL clear main and skid valid next edge, return to EMPTY, and discard any beat accepted in the same cycle; flush overrides all simultaneous events.
REQ-021 out_data SHALL hold its last value while out_valid=0; consumers qualify with out_valid.
REQ-022 Payload is opaque; no width truncation or arithmetic on data.

Reset
REQ-023 With rst low, asynchronously: out_valid=0, skid valid=0, in_ready=1, out_data=0, skid data=0, stall_cnt=0.
REQ-024 Reset mid-transfer SHALL discard both slots; the first edge after rst rises may accept a beat.

Configuration
REQ-025 Macro PIPE_STALL_CNT_EN defined: stall_cnt SHALL increment each cycle with out_valid && !out_ready, saturate at all-ones, unaffected by flush, cleared only by reset.
REQ-026 Macro PIPE_STALL_CNT_EN undefined: the stall_cnt port and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 Payload field widths (`BYTE, `WORD) and the default DATA_W composition SHALL live in the shared defines.v; no local redefinition.
REQ-028 The saturating counter SHALL be the sub-module pipe_sat_counter (parameter CNT_W; ports clk, rst, inc, cnt); slot control stays flat in pipe_skid_stage.

Verification
REQ-029 Streaming: in_valid=1, out_ready=1, data 0x01,0x02,0x03 on consecutive cycles -> out_data 0x01,0x02,0x03 one cycle later, out_valid=1 throughout, in_ready stays 1.
REQ-030 Backpressure: out_ready=0, send 0xA1 then 0xA2 -> FULL, in_ready=0, out_data=0xA1; raise out_ready -> 0xA1 then 0xA2 delivered, in_ready=1 after first drain.
REQ-031 Flush in FULL with in_valid=1 on that cycle -> next cycle out_valid=0, in_ready=1, no held or offered beat ever appears.
REQ-032 Async reset: drop rst between edges while FULL -> out_valid=0, in_ready=1 immediately, before next clk edge.
REQ-033 With PIPE_STALL_CNT_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush leaves it 15; reset gives 0.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and helpers for the two-slot skid pipeline stage.
`include "defines.v"

package pipe_skid_stage_pkg;

    localparam int DEFAULT_DATA_W = `PIPE_DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } slot_state_t;

    // The skid slot is only occupied in FULL.
    function automatic logic holds_skid(input slot_state_t s);
        return (s == ST_FULL);
    endfunction

endpackage

// File: rtl/defines.v
// Shared payload field widths for the pipeline stages.
// The default stage payload is icode+rA+rB (bytes) plus valA+valP+valE (words).
`ifndef PIPE_DEFINES_V
`define PIPE_DEFINES_V

`define BYTE 8
`define WORD 32
`define PIPE_DATA_W (3*`BYTE + 3*`WORD)

`endif

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-slot (main + skid) pipeline register stage with registered in_ready.
// Optional downstream-stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    slot_state_t       state_q, state_d;
    logic [DATA_W-1:0] skid_data;
    logic              in_xfer, out_xfer;
    logic              load_main, load_skid, skid_to_main;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d   = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (in_xfer) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d      = ST_ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready is its own flop so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= !holds_skid(state_d);
        end
    end

    // Data slots keep their contents when emptied; validity lives in state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                out_data <= in_data;
            end else if (skid_to_main) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus random traffic
// compared against a two-entry FIFO reference model.
module tb_pipe_skid_stage;

    localparam int DATA_W = 120;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Reference model: a FIFO of capacity two, the last shown head, and a stall count.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_last;
    int                m_cnt;

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit in_x, out_x;
        if (!rst) begin
            model_reset();
            return;
        end
        if (mq.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
        if (flush) begin
            mq.delete();
        end else begin
            in_x  = in_valid && (mq.size() < 2);
            out_x = (mq.size() > 0) && out_ready;
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(in_data);
        end
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
    endtask

    task automatic sync_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else passed++;
        total++;
        if (out_data !== '0) $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        logic [DATA_W-1:0] exp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = DATA_W'(i);
            tick();
            exp = DATA_W'(i);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp)
                $display("[TB] FAIL stream_beat%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, out_valid, out_data, exp);
            else passed++;
            total++;
            if (in_ready !== 1'b1) $display("[TB] FAIL stream_in_ready%0d: got %b expected 1", i, in_ready);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== DATA_W'(3))
            $display("[TB] FAIL stream_drain_hold: got valid=%b data=%h expected valid=0 data=3",
                     out_valid, out_data);
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(8'hA1);
        tick();
        in_data = DATA_W'(8'hA2);
        tick();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== DATA_W'(8'hA1))
            $display("[TB] FAIL bp_full: got rdy=%b valid=%b data=%h expected rdy=0 valid=1 data=a1",
                     in_ready, out_valid, out_data);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== DATA_W'(8'hA2))
            $display("[TB] FAIL bp_drain1: got rdy=%b valid=%b data=%h expected rdy=1 valid=1 data=a2",
                     in_ready, out_valid, out_data);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain2: got valid=%b expected 0", out_valid);
        else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(8'hB1);
        tick();
        in_data = DATA_W'(8'hB2);
        tick();
        flush   = 1'b1;
        in_data = DATA_W'(8'hB3);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL flush_full: got valid=%b rdy=%b expected valid=0 rdy=1", out_valid, in_ready);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) $display("[TB] FAIL flush_no_leak%0d: got valid=%b expected 0", i, out_valid);
            else passed++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(8'hC0);
        tick();
        in_data = DATA_W'(8'hC1);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
            $display("[TB] FAIL async_reset: got valid=%b rdy=%b data=%h expected valid=0 rdy=1 data=0",
                     out_valid, in_ready, out_data);
        else passed++;
        model_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = DATA_W'(8'hC2);
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(8'hC2))
            $display("[TB] FAIL post_reset_accept: got valid=%b data=%h expected valid=1 data=c2",
                     out_valid, out_data);
        else passed++;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        sync_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = DATA_W'(8'hD1);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        total++;
        if (stall_cnt !== CNT_W'(CNT_MAX)) $display("[TB] FAIL stall_saturate: got %0d expected %0d", stall_cnt, CNT_MAX);
        else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (stall_cnt !== CNT_W'(CNT_MAX)) $display("[TB] FAIL stall_after_flush: got %0d expected %0d", stall_cnt, CNT_MAX);
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (stall_cnt !== '0) $display("[TB] FAIL stall_reset: got %0d expected 0", stall_cnt);
        else passed++;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    task automatic test_random();
        logic [127:0] r;
        sync_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            total++;
            if (out_valid !== (mq.size() > 0))
                $display("[TB] FAIL rand_out_valid@%0d: got %b expected %b", cyc, out_valid, mq.size() > 0);
            else passed++;
            total++;
            if (in_ready !== (mq.size() < 2))
                $display("[TB] FAIL rand_in_ready@%0d: got %b expected %b", cyc, in_ready, mq.size() < 2);
            else passed++;
            total++;
            if (out_data !== m_last)
                $display("[TB] FAIL rand_out_data@%0d: got %h expected %h", cyc, out_data, m_last);
            else passed++;
`ifdef PIPE_STALL_CNT_EN
            total++;
            if (stall_cnt !== CNT_W'(m_cnt))
                $display("[TB] FAIL rand_stall_cnt@%0d: got %0d expected %0d", cyc, stall_cnt, m_cnt);
            else passed++;
`endif
            r         = {$urandom, $urandom, $urandom, $urandom};
            in_data   = r[DATA_W-1:0];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_async_reset();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
